// File: rtl/ddram_arb_pkg.sv
// Shared types and default widths for the two-port DDRAM burst arbiter.
package ddram_arb_pkg;

    localparam int DEF_AW  = 29;
    localparam int DEF_DW  = 64;
    localparam int DEF_BCW = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        WR_BURST = 2'd2,
        RD_WAIT  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ddram_arb_rr.sv
// Two-way round-robin picker: the port that did not win last time has
// priority; a lone requester always wins.
module ddram_arb_rr
    import ddram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    logic other;

    assign other = ~last;

    // Prefer the other port; fall back to the previous winner if it alone asks.
    always_comb begin
        winner = other;
        if (req[other]) begin
            winner = other;
        end else if (req[last]) begin
            winner = last;
        end
    end

endmodule

// File: rtl/ddram_arb2.sv
// Shares one emu-side 64-bit DDRAM burst port between two requesters.
// One transaction is outstanding at a time; grants alternate between
// ports when both keep requesting.
module ddram_arb2
    import ddram_arb_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int BEW = DW / 8,
    parameter int BCW = DEF_BCW
) (
    input  logic           clk_sys,
    input  logic           reset,

    input  logic           p0_rd,
    input  logic           p0_we,
    input  logic [AW-1:0]  p0_addr,
    input  logic [BCW-1:0] p0_burstcnt,
    input  logic [DW-1:0]  p0_din,
    input  logic [BEW-1:0] p0_be,
    output logic           p0_busy,
    output logic [DW-1:0]  p0_dout,
    output logic           p0_dout_ready,

    input  logic           p1_rd,
    input  logic           p1_we,
    input  logic [AW-1:0]  p1_addr,
    input  logic [BCW-1:0] p1_burstcnt,
    input  logic [DW-1:0]  p1_din,
    input  logic [BEW-1:0] p1_be,
    output logic           p1_busy,
    output logic [DW-1:0]  p1_dout,
    output logic           p1_dout_ready,

    input  logic           DDRAM_BUSY,
    input  logic [DW-1:0]  DDRAM_DOUT,
    input  logic           DDRAM_DOUT_READY,
    output logic           DDRAM_RD,
    output logic           DDRAM_WE,
    output logic [AW-1:0]  DDRAM_ADDR,
    output logic [BCW-1:0] DDRAM_BURSTCNT,
    output logic [DW-1:0]  DDRAM_DIN,
    output logic [BEW-1:0] DDRAM_BE
);

    // A zero burst count still moves one beat.
    function automatic logic [BCW-1:0] eff_burst(input logic [BCW-1:0] bc);
        return (bc == '0) ? BCW'(1) : bc;
    endfunction

    arb_state_t     state, state_nx;
    logic           gnt, gnt_nx;
    logic           last, last_nx;
    logic [BCW-1:0] cnt, cnt_nx;

    logic [1:0]     req;
    logic           winner;

    logic           g_rd;
    logic           g_we;
    logic           g_req;
    logic [AW-1:0]  g_addr;
    logic [BCW-1:0] g_burstcnt;
    logic [BCW-1:0] g_eff;
    logic [DW-1:0]  g_din;
    logic [BEW-1:0] g_be;

    logic           drive;
    logic [AW-1:0]  addr_hold;
    logic [BCW-1:0] burstcnt_hold;
    logic [DW-1:0]  din_hold;
    logic [BEW-1:0] be_hold;

    assign req = {p1_rd | p1_we, p0_rd | p0_we};

    ddram_arb_rr u_rr (
        .req    (req),
        .last   (last),
        .winner (winner)
    );

    // Select the granted port's command and write-data signals.
    always_comb begin
        g_rd       = p0_rd;
        g_we       = p0_we;
        g_addr     = p0_addr;
        g_burstcnt = p0_burstcnt;
        g_din      = p0_din;
        g_be       = p0_be;
        if (gnt) begin
            g_rd       = p1_rd;
            g_we       = p1_we;
            g_addr     = p1_addr;
            g_burstcnt = p1_burstcnt;
            g_din      = p1_din;
            g_be       = p1_be;
        end
    end

    assign g_req = g_rd | g_we;
    assign g_eff = eff_burst(g_burstcnt);

    // The memory port follows the granted requester only while commanding
    // or streaming write beats; otherwise it shows the last forwarded values.
    assign drive = (state == CMD) || (state == WR_BURST);

    // Arbiter state, grant, fairness history and beat counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: arbitrate, issue the command, then count beats.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nx   = winner;
                    last_nx  = winner;
                    state_nx = CMD;
                end
            end
            CMD: begin
                if (!g_req) begin
                    // Requester withdrew before the memory took the command.
                    state_nx = IDLE;
                end else if (!DDRAM_BUSY) begin
                    if (g_rd) begin
                        cnt_nx   = g_eff;
                        state_nx = RD_WAIT;
                    end else if (g_eff == BCW'(1)) begin
                        state_nx = IDLE;
                    end else begin
                        // First beat rides along with the command.
                        cnt_nx   = g_eff - BCW'(1);
                        state_nx = WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (g_we && !DDRAM_BUSY) begin
                    cnt_nx = cnt - BCW'(1);
                    if (cnt == BCW'(1)) begin
                        state_nx = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    cnt_nx = cnt - BCW'(1);
                    if (cnt == BCW'(1)) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Remember the last values presented to memory so they hold when idle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            addr_hold     <= '0;
            burstcnt_hold <= '0;
            din_hold      <= '0;
            be_hold       <= '0;
        end else if (drive) begin
            addr_hold     <= g_addr;
            burstcnt_hold <= g_burstcnt;
            din_hold      <= g_din;
            be_hold       <= g_be;
        end
    end

    // Memory-side command mux and per-port stall generation.
    always_comb begin
        p0_busy        = 1'b1;
        p1_busy        = 1'b1;
        DDRAM_RD       = 1'b0;
        DDRAM_WE       = 1'b0;
        DDRAM_ADDR     = addr_hold;
        DDRAM_BURSTCNT = burstcnt_hold;
        DDRAM_DIN      = din_hold;
        DDRAM_BE       = be_hold;
        if (drive) begin
            if (gnt) begin
                p1_busy = DDRAM_BUSY;
            end else begin
                p0_busy = DDRAM_BUSY;
            end
            DDRAM_ADDR     = g_addr;
            DDRAM_BURSTCNT = g_burstcnt;
            DDRAM_DIN      = g_din;
            DDRAM_BE       = g_be;
            if (state == CMD) begin
                // Read wins when a requester raises both strobes.
                DDRAM_RD = g_rd;
                DDRAM_WE = g_we & ~g_rd;
            end else begin
                DDRAM_WE = g_we;
            end
        end
    end

    // Read data is broadcast; only the owner of the pending read sees ready.
    assign p0_dout       = DDRAM_DOUT;
    assign p1_dout       = DDRAM_DOUT;
    assign p0_dout_ready = DDRAM_DOUT_READY & (state == RD_WAIT) & ~gnt;
    assign p1_dout_ready = DDRAM_DOUT_READY & (state == RD_WAIT) &  gnt;

endmodule

// File: tb/tb_ddram_arb2.sv
// Directed testbench for ddram_arb2 with a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_ddram_arb2;

    localparam int AW  = 29;
    localparam int DW  = 64;
    localparam int BEW = 8;
    localparam int BCW = 8;

    logic           clk_sys;
    logic           reset;

    logic           p0_rd, p0_we;
    logic [AW-1:0]  p0_addr;
    logic [BCW-1:0] p0_burstcnt;
    logic [DW-1:0]  p0_din;
    logic [BEW-1:0] p0_be;
    logic           p0_busy;
    logic [DW-1:0]  p0_dout;
    logic           p0_dout_ready;

    logic           p1_rd, p1_we;
    logic [AW-1:0]  p1_addr;
    logic [BCW-1:0] p1_burstcnt;
    logic [DW-1:0]  p1_din;
    logic [BEW-1:0] p1_be;
    logic           p1_busy;
    logic [DW-1:0]  p1_dout;
    logic           p1_dout_ready;

    logic           DDRAM_BUSY;
    logic [DW-1:0]  DDRAM_DOUT;
    logic           DDRAM_DOUT_READY;
    logic           DDRAM_RD;
    logic           DDRAM_WE;
    logic [AW-1:0]  DDRAM_ADDR;
    logic [BCW-1:0] DDRAM_BURSTCNT;
    logic [DW-1:0]  DDRAM_DIN;
    logic [BEW-1:0] DDRAM_BE;

    // memory-side drivers: directed pulses and an automatic read responder
    logic           dir_rdy, resp_rdy, auto_resp;
    logic [DW-1:0]  dir_dout, resp_dout;
    int             resp_left;

    assign DDRAM_DOUT_READY = dir_rdy | resp_rdy;
    assign DDRAM_DOUT       = resp_rdy ? resp_dout : dir_dout;

    ddram_arb2 dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .p0_rd            (p0_rd),
        .p0_we            (p0_we),
        .p0_addr          (p0_addr),
        .p0_burstcnt      (p0_burstcnt),
        .p0_din           (p0_din),
        .p0_be            (p0_be),
        .p0_busy          (p0_busy),
        .p0_dout          (p0_dout),
        .p0_dout_ready    (p0_dout_ready),
        .p1_rd            (p1_rd),
        .p1_we            (p1_we),
        .p1_addr          (p1_addr),
        .p1_burstcnt      (p1_burstcnt),
        .p1_din           (p1_din),
        .p1_be            (p1_be),
        .p1_busy          (p1_busy),
        .p1_dout          (p1_dout),
        .p1_dout_ready    (p1_dout_ready),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_WE         (DDRAM_WE),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [BCW-1:0] b);
        return (b == 0) ? 1 : int'(b);
    endfunction

    // the port that did not win last time goes first
    function automatic bit pick(input bit r0, input bit r1, input bit prev);
        if (prev) return r0 ? 1'b0 : 1'b1;
        else      return r1 ? 1'b1 : 1'b0;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    int             cyc = 0;
    bit             m_valid = 0;
    bit             m_last, m_owner, m_pend;
    int             m_wr_left, m_rd_left;
    logic [AW-1:0]  m_h_addr;
    logic [BCW-1:0] m_h_bc;
    logic [DW-1:0]  m_h_din;
    logic [BEW-1:0] m_h_be;

    logic           own_rd, own_we;
    logic [AW-1:0]  own_addr;
    logic [BCW-1:0] own_bc;
    logic [DW-1:0]  own_din;
    logic [BEW-1:0] own_be;

    assign own_rd   = m_owner ? p1_rd       : p0_rd;
    assign own_we   = m_owner ? p1_we       : p0_we;
    assign own_addr = m_owner ? p1_addr     : p0_addr;
    assign own_bc   = m_owner ? p1_burstcnt : p0_burstcnt;
    assign own_din  = m_owner ? p1_din      : p0_din;
    assign own_be   = m_owner ? p1_be       : p0_be;

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_valid   <= 1'b1;
            m_last    <= 1'b1;
            m_owner   <= 1'b0;
            m_pend    <= 1'b0;
            m_wr_left <= 0;
            m_rd_left <= 0;
            m_h_addr  <= '0;
            m_h_bc    <= '0;
            m_h_din   <= '0;
            m_h_be    <= '0;
        end else begin
            if (m_pend || m_wr_left > 0) begin
                m_h_addr <= own_addr;
                m_h_bc   <= own_bc;
                m_h_din  <= own_din;
                m_h_be   <= own_be;
            end
            if (!m_pend && m_wr_left == 0 && m_rd_left == 0) begin
                if (p0_rd || p0_we || p1_rd || p1_we) begin
                    m_owner <= pick(p0_rd | p0_we, p1_rd | p1_we, m_last);
                    m_last  <= pick(p0_rd | p0_we, p1_rd | p1_we, m_last);
                    m_pend  <= 1'b1;
                end
            end else if (m_pend) begin
                if (!(own_rd || own_we)) begin
                    m_pend <= 1'b0;
                end else if (!DDRAM_BUSY) begin
                    m_pend <= 1'b0;
                    if (own_rd) m_rd_left <= eff(own_bc);
                    else        m_wr_left <= eff(own_bc) - 1;
                end
            end else if (m_wr_left > 0) begin
                if (own_we && !DDRAM_BUSY) m_wr_left <= m_wr_left - 1;
            end else if (DDRAM_DOUT_READY) begin
                m_rd_left <= m_rd_left - 1;
            end
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    int             rd_hi = 0, rd_cyc = 0, rdy0 = 0, rdy1 = 0;
    int             grants[$];
    logic [DW-1:0]  wr_din[$];
    logic [BEW-1:0] wr_be[$];

    initial begin
        forever begin
            @(negedge clk_sys);
            if (m_valid) begin
                bit e_drv;
                e_drv = m_pend || (m_wr_left > 0);
                chk("busy0", p0_busy, (e_drv && !m_owner) ? DDRAM_BUSY : 1'b1);
                chk("busy1", p1_busy, (e_drv &&  m_owner) ? DDRAM_BUSY : 1'b1);
                chk("ddram_rd", DDRAM_RD, m_pend && own_rd);
                chk("ddram_we", DDRAM_WE, (m_pend && own_we && !own_rd) || (m_wr_left > 0 && own_we));
                chk("rdy0", p0_dout_ready, (m_rd_left > 0) && !m_owner && DDRAM_DOUT_READY);
                chk("rdy1", p1_dout_ready, (m_rd_left > 0) &&  m_owner && DDRAM_DOUT_READY);
                chk("dout0", p0_dout, DDRAM_DOUT);
                chk("dout1", p1_dout, DDRAM_DOUT);
                chk("ddram_addr", DDRAM_ADDR,     e_drv ? own_addr : m_h_addr);
                chk("ddram_bc",   DDRAM_BURSTCNT, e_drv ? own_bc   : m_h_bc);
                chk("ddram_din",  DDRAM_DIN,      e_drv ? own_din  : m_h_din);
                chk("ddram_be",   DDRAM_BE,       e_drv ? own_be   : m_h_be);
                if (DDRAM_RD) rd_hi++;
                if (DDRAM_RD && !DDRAM_BUSY) begin
                    rd_cyc = cyc;
                    grants.push_back(p0_busy ? 1 : 0);
                end
                if (DDRAM_WE && !DDRAM_BUSY) begin
                    wr_din.push_back(DDRAM_DIN);
                    wr_be.push_back(DDRAM_BE);
                end
                if (p0_dout_ready) rdy0++;
                if (p1_dout_ready) rdy1++;
            end
        end
    end

    // automatic responder: one beat per cycle for each accepted read
    initial begin
        resp_rdy  = 1'b0;
        resp_dout = '0;
        resp_left = 0;
        forever begin
            @(negedge clk_sys);
            if (auto_resp && DDRAM_RD && !DDRAM_BUSY) resp_left += eff(DDRAM_BURSTCNT);
            @(posedge clk_sys);
            #1;
            if (resp_left > 0) begin
                resp_rdy  = 1'b1;
                resp_dout = 64'hC0DE_0000_0000_0000 | 64'(cyc);
                resp_left--;
            end else begin
                resp_rdy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    int             b_hi, b_r0, b_r1, gsz, wsz, req_cyc, n0, n1;
    bit             ok, a0, a1;
    int             exp_g[4];
    logic [DW-1:0]  exp_din[3];
    logic [BEW-1:0] exp_be[3];

    initial begin
        reset = 1'b1;
        p0_rd = 0; p0_we = 0; p0_addr = '0; p0_burstcnt = '0; p0_din = '0; p0_be = '0;
        p1_rd = 0; p1_we = 0; p1_addr = '0; p1_burstcnt = '0; p1_din = '0; p1_be = '0;
        DDRAM_BUSY = 0; dir_rdy = 0; dir_dout = '0; auto_resp = 0;
        exp_g   = '{0, 1, 0, 1};
        exp_din = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
        exp_be  = '{8'hFF, 8'h0F, 8'hF0};

        // T1: single 4-beat read from port 0
        do_reset();
        chk("t1_reset_busy0", p0_busy, 1);
        chk("t1_reset_rd", DDRAM_RD, 0);
        b_hi = rd_hi; b_r0 = rdy0; b_r1 = rdy1;
        p0_rd = 1; p0_addr = 29'h100; p0_burstcnt = 4; req_cyc = cyc;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            ok = !p0_busy;
            tick();
        end
        p0_rd = 0;
        chk("t1_accept", ok, 1);
        chk("t1_rd_latency", rd_cyc - req_cyc, 1);
        for (int i = 0; i < 4; i++) begin
            dir_rdy = 1; dir_dout = 64'hA000 + 64'(i);
            tick();
            dir_rdy = 0;
            tick();
        end
        chk("t1_rd_pulses", rd_hi - b_hi, 1);
        chk("t1_p0_beats", rdy0 - b_r0, 4);
        chk("t1_p1_beats", rdy1 - b_r1, 0);
        chk("t1_idle_busy0", p0_busy, 1);

        // T2: both ports read continuously, grants must alternate
        do_reset();
        gsz = grants.size(); b_r0 = rdy0; b_r1 = rdy1;
        auto_resp = 1;
        p0_addr = 29'h10; p1_addr = 29'h20; p0_burstcnt = 1; p1_burstcnt = 1;
        p0_rd = 1; p1_rd = 1; n0 = 0; n1 = 0;
        for (int c = 0; c < 80 && (n0 < 2 || n1 < 2); c++) begin
            a0 = !p0_busy; a1 = !p1_busy;
            tick();
            if (a0) begin n0++; if (n0 >= 2) p0_rd = 0; end
            if (a1) begin n1++; if (n1 >= 2) p1_rd = 0; end
        end
        repeat (4) tick();
        auto_resp = 0;
        chk("t2_p0_accepts", n0, 2);
        chk("t2_p1_accepts", n1, 2);
        chk("t2_grant_count", grants.size() - gsz, 4);
        for (int i = 0; i < 4; i++)
            if (gsz + i < grants.size()) chk("t2_grant_order", grants[gsz + i], exp_g[i]);
        chk("t2_p0_beats", rdy0 - b_r0, 2);
        chk("t2_p1_beats", rdy1 - b_r1, 2);

        // T3: port 1 write, burst 3, one memory stall and one requester bubble
        do_reset();
        wsz = wr_din.size();
        p1_we = 1; p1_addr = 29'h200; p1_burstcnt = 3; p1_din = exp_din[0]; p1_be = exp_be[0];
        tick();
        chk("t3_cmd_busy1", p1_busy, 0);
        tick();
        p1_din = exp_din[1]; p1_be = exp_be[1]; DDRAM_BUSY = 1;
        tick();
        DDRAM_BUSY = 0;
        tick();
        p1_we = 0;
        tick();
        p1_we = 1; p1_din = exp_din[2]; p1_be = exp_be[2];
        tick();
        p1_we = 0;
        chk("t3_idle_busy1", p1_busy, 1);
        chk("t3_idle_we", DDRAM_WE, 0);
        chk("t3_beats", wr_din.size() - wsz, 3);
        for (int i = 0; i < 3; i++)
            if (wsz + i < wr_din.size()) begin
                chk("t3_din", wr_din[wsz + i], exp_din[i]);
                chk("t3_be", wr_be[wsz + i], exp_be[i]);
            end

        // T4: burst count 0 write acts as a single beat, next request granted
        wsz = wr_din.size(); gsz = grants.size(); b_r1 = rdy1;
        p0_we = 1; p0_addr = 29'h300; p0_burstcnt = 0; p0_din = 64'hDEAD_BEEF_0000_0001; p0_be = 8'h3C;
        tick();
        tick();
        p0_we = 0;
        chk("t4_idle_busy0", p0_busy, 1);
        chk("t4_beats", wr_din.size() - wsz, 1);
        if (wsz < wr_din.size()) chk("t4_din", wr_din[wsz], 64'hDEAD_BEEF_0000_0001);
        auto_resp = 1;
        p1_rd = 1; p1_addr = 29'h340; p1_burstcnt = 2;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            ok = !p1_busy;
            tick();
        end
        p1_rd = 0;
        repeat (5) tick();
        auto_resp = 0;
        chk("t4_next_accept", ok, 1);
        chk("t4_p1_beats", rdy1 - b_r1, 2);
        chk("t4_grant_count", grants.size() - gsz, 1);

        // T5: stray read beats while idle are not routed
        b_r0 = rdy0; b_r1 = rdy1;
        dir_rdy = 1; dir_dout = 64'hBAD0_BAD0;
        repeat (3) tick();
        dir_rdy = 0;
        tick();
        chk("t5_p0_stray", rdy0 - b_r0, 0);
        chk("t5_p1_stray", rdy1 - b_r1, 0);

        // T6: reset in the middle of an 8-beat read
        do_reset();
        b_r0 = rdy0; b_r1 = rdy1;
        p0_rd = 1; p0_addr = 29'h400; p0_burstcnt = 8; p0_din = 64'h0123; p0_be = 8'h55;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            ok = !p0_busy;
            tick();
        end
        p0_rd = 0;
        chk("t6_accept", ok, 1);
        for (int i = 0; i < 2; i++) begin
            dir_rdy = 1; dir_dout = 64'hE000 + 64'(i);
            tick();
        end
        dir_rdy = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("t6_rst_busy0", p0_busy, 1);
        chk("t6_rst_busy1", p1_busy, 1);
        chk("t6_rst_rd", DDRAM_RD, 0);
        chk("t6_rst_we", DDRAM_WE, 0);
        chk("t6_rst_addr", DDRAM_ADDR, 0);
        chk("t6_rst_bc", DDRAM_BURSTCNT, 0);
        chk("t6_rst_din", DDRAM_DIN, 0);
        chk("t6_rst_be", DDRAM_BE, 0);
        for (int i = 0; i < 6; i++) begin
            dir_rdy = 1; dir_dout = 64'hE100 + 64'(i);
            tick();
        end
        dir_rdy = 0;
        chk("t6_p0_beats", rdy0 - b_r0, 2);
        gsz = grants.size();
        auto_resp = 1;
        p1_rd = 1; p1_addr = 29'h500; p1_burstcnt = 1;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            ok = !p1_busy;
            tick();
        end
        p1_rd = 0;
        repeat (4) tick();
        auto_resp = 0;
        chk("t6_p1_accept", ok, 1);
        chk("t6_p1_beats", rdy1 - b_r1, 1);
        chk("t6_grant_count", grants.size() - gsz, 1);
        if (gsz < grants.size()) chk("t6_grant_port", grants[gsz], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
